// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Brief    : Execute stage behind the ALU control decoder. Single-cycle
//             AND/OR/ADD/SUB/SLT, iterative shift-add MUL (low half) over
//             WIDTH cycles, valid/ready input handshake, registered outputs.
//  Revision : 1.0  initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             illegal_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] acc_sum;

  assign ready_o   = (state_q == S_IDLE);
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign valid_o   = valid_q;
  assign illegal_o = illegal_q;

  // Partial-product step: add the shifted multiplicand when the multiplier LSB is set.
  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Single-cycle operations; unsupported codes yield zero and flag illegal.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state logic for the IDLE/MUL controller and the output registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    result_d  = result_q;
    zero_d    = zero_q;
    valid_d   = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (ctrl_i == OP_MUL) begin
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = '0;
            cnt_d    = CNT_INIT;
            state_d  = S_MUL;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            valid_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d  = acc_sum;
          zero_d    = (acc_sum == '0);
          illegal_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any multiply in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Brief    : Self-checking bench for alu_exec_unit with directed scenarios
//             and randomized operations against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic             clk_i;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             valid_o;
  logic             illegal_o;

  int total;
  int bad;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ctrl_i    (ctrl_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .valid_o   (valid_o),
    .illegal_o (illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural model: {illegal, result}
  function automatic logic [WIDTH:0] ref_op(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic             ill;
    longint           sa, sb;
    r   = '0;
    ill = 1'b0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = (sa < sb) ? 1 : 0;
      4'b0011: r = WIDTH'(longint'(a) * longint'(b));
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  // Present a request and hold it until the accepting edge; returns 1ns after that edge.
  task automatic issue(input logic [3:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  // Advance cycles until valid_o is seen or the budget runs out; cyc = cycles waited (-1 on timeout).
  task automatic wait_valid(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i   = 1'b0;
    valid_i = 1'b0;
    ctrl_i  = '0;
    src1_i  = '0;
    src2_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if ({result_o, zero_o, valid_o, illegal_o, ready_o} !== {{WIDTH{1'b0}}, 4'b1001}) begin
      bad++;
      $display("FAIL reset: res=%h z=%b v=%b ill=%b rdy=%b required res=0 z=1 v=0 ill=0 rdy=1",
               result_o, zero_o, valid_o, illegal_o, ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_add();
    issue(4'b0010, 32'd5, 32'd7);
    total++;
    if ({valid_o, result_o, zero_o, ready_o} !== {1'b1, 32'd12, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL add: v=%b res=%0d z=%b rdy=%b required v=1 res=12 z=0 rdy=1",
               valid_o, result_o, zero_o, ready_o);
    end
  endtask

  task automatic test_back_to_back();
    issue(4'b0110, 32'd3, 32'd3);
    total++;
    if ({valid_o, result_o, zero_o} !== {1'b1, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL sub_zero: v=%b res=%h z=%b required v=1 res=0 z=1", valid_o, result_o, zero_o);
    end
    issue(4'b0110, 32'd0, 32'd1);
    total++;
    if ({valid_o, result_o, zero_o} !== {1'b1, 32'hFFFF_FFFF, 1'b0}) begin
      bad++;
      $display("FAIL sub_wrap: v=%b res=%h z=%b required v=1 res=ffffffff z=0", valid_o, result_o, zero_o);
    end
  endtask

  task automatic test_logic_slt();
    logic [3:0]       c [4];
    logic [WIDTH-1:0] a [4];
    logic [WIDTH-1:0] b [4];
    logic [WIDTH-1:0] e [4];
    c[0] = 4'b0111; a[0] = 32'hFFFF_FFFF; b[0] = 32'd1;       e[0] = 32'd1;
    c[1] = 4'b0111; a[1] = 32'd1;         b[1] = 32'hFFFF_FFFF; e[1] = 32'd0;
    c[2] = 4'b0000; a[2] = 32'hF0F0;      b[2] = 32'hFF00;    e[2] = 32'hF000;
    c[3] = 4'b0001; a[3] = 32'hF0F0;      b[3] = 32'h0F0F;    e[3] = 32'hFFFF;
    for (int i = 0; i < 4; i++) begin
      issue(c[i], a[i], b[i]);
      total++;
      if ({valid_o, result_o, illegal_o} !== {1'b1, e[i], 1'b0}) begin
        bad++;
        $display("FAIL logic_slt[%0d]: v=%b res=%h ill=%b required v=1 res=%h ill=0",
                 i, valid_o, result_o, illegal_o, e[i]);
      end
    end
  endtask

  task automatic test_mul_busy();
    int cyc;
    int busy_bad;
    busy_bad = 0;
    issue(4'b0011, 32'd6, 32'd7);
    // Hold an ADD request throughout the busy window.
    ctrl_i  = 4'b0010;
    src1_i  = 32'd100;
    src2_i  = 32'd23;
    valid_i = 1'b1;
    total++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL mul_accept: rdy=%b v=%b required rdy=0 v=0", ready_o, valid_o);
    end
    cyc = -1;
    for (int i = 1; i <= WIDTH + 4; i++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) begin
        cyc = i;
        break;
      end
      if (ready_o !== 1'b0) busy_bad++;
    end
    total++;
    if (cyc != WIDTH || result_o !== 32'd42 || zero_o !== 1'b0 || busy_bad != 0) begin
      bad++;
      $display("FAIL mul_6x7: cycles=%0d res=%0d z=%b busy_rdy_errs=%0d required cycles=%0d res=42 z=0 errs=0",
               cyc, result_o, zero_o, busy_bad, WIDTH);
    end
    // Held ADD is accepted once ready returns.
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    total++;
    if (valid_o !== 1'b1 || result_o !== 32'd123) begin
      bad++;
      $display("FAIL held_add: v=%b res=%0d required v=1 res=123", valid_o, result_o);
    end
    @(posedge clk_i);
    #1;
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL extra_accept: v=%b required v=0", valid_o);
    end
  endtask

  task automatic test_mul_edges();
    int cyc;
    issue(4'b0011, 32'hFFFF_FFFF, 32'd2);
    wait_valid(WIDTH + 4, cyc);
    total++;
    if (cyc != WIDTH || result_o !== 32'hFFFF_FFFE || zero_o !== 1'b0) begin
      bad++;
      $display("FAIL mul_wrap: cycles=%0d res=%h z=%b required cycles=%0d res=fffffffe z=0",
               cyc, result_o, zero_o, WIDTH);
    end
    issue(4'b0011, 32'h1234_5678, 32'd0);
    wait_valid(WIDTH + 4, cyc);
    total++;
    if (cyc != WIDTH || result_o !== 32'd0 || zero_o !== 1'b1) begin
      bad++;
      $display("FAIL mul_zero: cycles=%0d res=%h z=%b required cycles=%0d res=0 z=1",
               cyc, result_o, zero_o, WIDTH);
    end
  endtask

  task automatic test_illegal();
    issue(4'b0010, 32'd1, 32'd1);
    issue(4'b1111, 32'd9, 32'd9);
    total++;
    if ({valid_o, illegal_o, result_o, zero_o} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL illegal: v=%b ill=%b res=%h z=%b required v=1 ill=1 res=0 z=1",
               valid_o, illegal_o, result_o, zero_o);
    end
    issue(4'b0010, 32'd2, 32'd3);
    total++;
    if ({valid_o, illegal_o, result_o} !== {1'b1, 1'b0, 32'd5}) begin
      bad++;
      $display("FAIL illegal_clear: v=%b ill=%b res=%0d required v=1 ill=0 res=5",
               valid_o, illegal_o, result_o);
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    issue(4'b0010, 32'd40, 32'd2);
    issue(4'b0011, 32'd9, 32'd9);
    repeat (10) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    total++;
    if ({result_o, zero_o, valid_o, illegal_o, ready_o} !== {{WIDTH{1'b0}}, 4'b1001}) begin
      bad++;
      $display("FAIL reset_mid_mul: res=%h z=%b v=%b ill=%b rdy=%b required res=0 z=1 v=0 ill=0 rdy=1",
               result_o, zero_o, valid_o, illegal_o, ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    seen = 0;
    for (int i = 0; i < WIDTH + 8; i++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_no_valid: pulses=%0d required 0", seen);
    end
  endtask

  task automatic test_random();
    logic [3:0]       codes [9];
    logic [3:0]       c;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   exp;
    int               cyc;
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010;
    codes[3] = 4'b0110; codes[4] = 4'b0111; codes[5] = 4'b0011;
    codes[6] = 4'b0100; codes[7] = 4'b1010; codes[8] = 4'b1111;
    for (int n = 0; n < 150; n++) begin
      c = codes[$urandom_range(8)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(7))
        0: a = '0;
        1: b = '0;
        2: b = a;
        3: a = {1'b1, {(WIDTH-1){1'b0}}};
        default: ;
      endcase
      exp = ref_op(c, a, b);
      issue(c, a, b);
      if (c == 4'b0011) wait_valid(WIDTH + 4, cyc);
      else cyc = valid_o ? 0 : -1;
      total++;
      if (cyc < 0 || result_o !== exp[WIDTH-1:0] || illegal_o !== exp[WIDTH] ||
          zero_o !== (exp[WIDTH-1:0] == '0)) begin
        bad++;
        $display("FAIL random[%0d] ctrl=%b a=%h b=%h: cyc=%0d res=%h ill=%b z=%b required res=%h ill=%b",
                 n, c, a, b, cyc, result_o, illegal_o, zero_o, exp[WIDTH-1:0], exp[WIDTH]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_logic_slt();
    test_mul_busy();
    test_mul_edges();
    test_illegal();
    test_reset_mid_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
